// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - decoded-instruction pipeline stage with skid buffer, flush and debug counters
module pipe_stage_reg #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 3,
  parameter int IMM_W     = 8,
  parameter int CNT_W     = 11
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_format,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic                 in_sign,
  input  logic [OPERAND_W-1:0] in_operand,
  input  logic [IMM_W-1:0]     in_immediate,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_format,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic                 out_sign,
  output logic [OPERAND_W-1:0] out_operand,
  output logic [IMM_W-1:0]     out_immediate,
  output logic [CNT_W-1:0]     issue_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int DATA_W = 2 + OPCODE_W + OPERAND_W + IMM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] in_data;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        flush_inc;
  logic [CNT_W:0]    flush_sum;

  assign in_data  = {in_format, in_opcode, in_sign, in_operand, in_immediate};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // in_ready comes straight from the skid flop, so upstream never sees a comb path
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign {out_format, out_opcode, out_sign, out_operand, out_immediate} = main_data;

  // Empty slots hold zero data so a bubble presents as opcode 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end
    end else if (out_fire) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (in_fire) begin
        main_data <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= '0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

  // An entry leaving downstream in the flush cycle is issued, not flushed
  assign flush_inc = {1'b0, main_valid & ~out_fire} + {1'b0, skid_valid};
  assign flush_sum = {1'b0, flush_count} + (CNT_W + 1)'(flush_inc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issue_count <= '0;
      flush_count <= '0;
    end else begin
      if (out_fire && issue_count != CNT_MAX)
        issue_count <= issue_count + CNT_W'(1);
      if (flush) begin
        if (flush_sum > {1'b0, CNT_MAX})
          flush_count <= CNT_MAX;
        else
          flush_count <= flush_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DW = 17;
  localparam int MAX11 = 2047;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_format = 1'b0;
  logic [3:0] in_opcode = '0;
  logic       in_sign = 1'b0;
  logic [2:0] in_operand = '0;
  logic [7:0] in_immediate = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_format;
  logic [3:0] out_opcode;
  logic       out_sign;
  logic [2:0] out_operand;
  logic [7:0] out_immediate;
  logic [10:0] issue_count;
  logic [10:0] flush_count;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic       s_out_valid;
  logic       s_out_format;
  logic [3:0] s_out_opcode;
  logic       s_out_sign;
  logic [2:0] s_out_operand;
  logic [7:0] s_out_immediate;
  logic [1:0] s_issue_count;
  logic [1:0] s_flush_count;

  always #5 clock = ~clock;

  pipe_stage_reg u_dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_format(in_format), .in_opcode(in_opcode), .in_sign(in_sign),
    .in_operand(in_operand), .in_immediate(in_immediate),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_format(out_format), .out_opcode(out_opcode), .out_sign(out_sign),
    .out_operand(out_operand), .out_immediate(out_immediate),
    .issue_count(issue_count), .flush_count(flush_count)
  );

  pipe_stage_reg #(.CNT_W(2)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_format(in_format), .in_opcode(in_opcode), .in_sign(in_sign),
    .in_operand(in_operand), .in_immediate(in_immediate),
    .flush(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_format(s_out_format), .out_opcode(s_out_opcode), .out_sign(s_out_sign),
    .out_operand(s_out_operand), .out_immediate(s_out_immediate),
    .issue_count(s_issue_count), .flush_count(s_flush_count)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [DW-1:0] sb[$];
  int exp_issue = 0;
  int exp_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: occupancy and order come from the queue of accepted entries
  int            occ;
  logic          m_in_fire;
  logic          m_out_fire;
  logic [DW-1:0] m_exp;
  always @(negedge clock) begin
    m_in_fire  = in_valid & in_ready & ~flush & reset_n;
    occ        = sb.size() - (m_in_fire ? 1 : 0);
    check("out_valid", 32'(out_valid), 32'(occ > 0));
    check("in_ready", 32'(in_ready), 32'(occ < 2));
    if (!out_valid)
      check("bubble_zero", 32'({out_format, out_opcode, out_sign, out_operand, out_immediate}), 32'd0);
    check("issue_count", 32'(issue_count), 32'(exp_issue));
    check("flush_count", 32'(flush_count), 32'(exp_flush));
    m_out_fire = out_valid & out_ready & reset_n;
    if (m_out_fire) begin
      if (occ == 0) begin
        check("spurious_out", 32'(out_opcode), 32'hFFFF_FFFF);
      end else begin
        m_exp = sb.pop_front();
        check("out_data", 32'({out_format, out_opcode, out_sign, out_operand, out_immediate}), 32'(m_exp));
        exp_issue = (exp_issue < MAX11) ? exp_issue + 1 : MAX11;
      end
    end
    if (flush && reset_n) begin
      exp_flush = exp_flush + sb.size();
      if (exp_flush > MAX11) exp_flush = MAX11;
      sb.delete();
    end
  end

  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl,
                     output logic acc);
    @(posedge clock);
    #1;
    in_valid  = v;
    {in_format, in_opcode, in_sign, in_operand, in_immediate} = d;
    out_ready = ordy;
    flush     = fl;
    acc = v & in_ready & ~fl;
    if (acc) sb.push_back(d);
  endtask

  function automatic logic [DW-1:0] mk(input logic [3:0] op, input logic [7:0] imm);
    return {1'b0, op, 1'b0, 3'd0, imm};
  endfunction

  logic acc;
  int   idx;

  initial begin
    #12 reset_n = 1'b1;

    // CNT_W=2 instance: five issues saturate at 3
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1 s_in_valid = 1'b1;
    end
    @(posedge clock); #1 s_in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 check("sat_issue", 32'(s_issue_count), 32'd3);
    check("sat_flush", 32'(s_flush_count), 32'd0);

    // Single entry: opcode 5, immediate A3
    cyc(1'b1, mk(4'h5, 8'hA3), 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);

    // Stream 1..4 with downstream stalled three cycles
    idx = 1;
    for (int c = 0; c < 20; c++) begin
      cyc(idx <= 4, mk(4'(idx), 8'(idx * 17)), !(c >= 2 && c <= 4), 1'b0, acc);
      if (acc) idx++;
    end
    check("stream_issue", 32'(issue_count), 32'd5);

    // Fill both slots, then flush while opcode 7 is offered
    idx = 0;
    for (int c = 0; c < 8 && idx < 2; c++) begin
      cyc(1'b1, mk(4'(idx + 9), 8'h11), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b1, mk(4'h7, 8'h77), 1'b0, 1'b1, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check("flush_two", 32'(flush_count), 32'd2);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);

    // Flush coinciding with out_fire of a lone entry
    cyc(1'b1, mk(4'hC, 8'h5A), 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b0, 1'b0, acc);
    cyc(1'b0, '0, 1'b1, 1'b1, acc);
    cyc(1'b0, '0, 1'b1, 1'b0, acc);
    check("flush_fire_issue", 32'(issue_count), 32'd6);
    check("flush_fire_flush", 32'(flush_count), 32'd2);

    // Random traffic
    for (int c = 0; c < 3000; c++)
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0, acc);

    // Mid-stream asynchronous reset
    cyc(1'b1, mk(4'h3, 8'h33), 1'b0, 1'b0, acc);
    cyc(1'b1, mk(4'h4, 8'h44), 1'b0, 1'b0, acc);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    sb.delete();
    exp_issue = 0;
    exp_flush = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_opcode", 32'(out_opcode), 32'd0);
    check("rst_issue", 32'(issue_count), 32'd0);
    check("rst_flush", 32'(flush_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Short random burst after reset, then drain
    for (int c = 0; c < 200; c++)
      cyc($urandom_range(0, 1) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, acc);
    for (int c = 0; c < 6; c++)
      cyc(1'b0, '0, 1'b1, 1'b0, acc);
    @(negedge clock);
    check("drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register carrying decoded instruction fields (format, opcode, sign, operand, immediate) between CPU pipeline stages.
- Replaces the fixed-width, dual-edge IF/ID latch with a single-edge stage that has:
  - valid/ready handshake
  - 2-entry skid buffer for stalls
  - synchronous flush
  - saturating issue and flush counters for debug
- Instantiated between every stage pair (IF/ID, ID/EX, EX/WB).

Parameters:
- OPCODE_W, 4, opcode field width
- OPERAND_W, 3, operand/register-select field width
- IMM_W, 8, immediate field width
- CNT_W, 11, width of issue_count and flush_count

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered
- in_format  in  1  format bit
- in_opcode  in  OPCODE_W  opcode
- in_sign  in  1  sign bit
- in_operand  in  OPERAND_W  operand
- in_immediate  in  IMM_W  immediate
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  output slot holds an instruction
- out_ready  in  1  downstream accepts
- out_format  out  1  held format
- out_opcode  out  OPCODE_W  held opcode
- out_sign  out  1  held sign
- out_operand  out  OPERAND_W  held operand
- out_immediate  out  IMM_W  held immediate
- issue_count  out  CNT_W  instructions delivered downstream
- flush_count  out  CNT_W  entries discarded by flush

Behaviour:
- Reset (async assert, sync deassert by use):
  - out_valid=0, all out_* fields=0, in_ready=1
  - both counters=0, skid slot empty
- Storage: main slot (drives out_* directly from flops) and skid slot. No combinational path from in_* to out_*.
- Events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- in_ready = !skid_valid, registered.
- Latency: empty stage, in_fire at edge N → out_valid=1 with those fields after edge N. Throughput 1/cycle while out_ready=1.
- Per posedge, no flush:
  - main empty, in_fire: load main from input.
  - main full, out_fire, skid full: main←skid; skid←input if in_fire (cannot occur, since in_ready=0), else skid empty.
  - main full, out_fire, skid empty: main←input if in_fire, else main empty.
  - main full, no out_fire, in_fire: skid←input; in_ready drops to 0 next cycle.
  - main full, no out_fire, no in_fire: hold.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped except by flush.
- Empty main slot: out_* fields forced to 0, so a bubble is opcode 0 (NOP).
- Flush (highest priority, synchronous):
  - Clears main and skid slots and zeroes out_* fields.
  - in_ready=1 next cycle.
  - An input presented in the flush cycle is discarded and not counted.
  - out_fire in the flush cycle still counts as issued; that entry is not counted as flushed.
  - flush_count += number of valid entries discarded (0, 1 or 2).
- Counters:
  - issue_count += 1 on each out_fire.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
  - Both counters are cleared only by reset.
- Fields are stored exactly at parameter width; no sign extension or truncation.

Test Plan:
- Reset, then in_valid=1, opcode=4'h5, immediate=8'hA3, out_ready=1 → out_valid=1, out_opcode=5, out_immediate=A3 after 1 edge; issue_count=1 after the next edge.
- Stream opcodes 1,2,3,4 back-to-back; hold out_ready=0 from cycle 2 for 3 cycles:
  - skid fills, in_ready=0, no loss
  - on release, outputs appear in order 1,2,3,4
  - issue_count=4
- Fill both slots, pulse flush with in_valid=1 (opcode 7) → out_valid=0, out_opcode=0, in_ready=1, flush_count=2; opcode 7 never appears at the output.
- Flush with out_fire on a single held entry → issue_count+1, flush_count unchanged, stage empty.
- Assert reset_n=0 mid-stream, between clock edges → outputs and counters zero immediately; in_ready=1.
- CNT_W=2, issue 5 instructions → issue_count stays at 3.
